// File: rtl/sopc_2_mem_master_pkg.sv
// sopc_2_mem_master_pkg: shared types and constants for the Avalon-MM block mover
//   ADDR_W_DEF / DATA_W_DEF : default word-address and data widths
//   MEM_DEPTH               : words physically present in the attached memory
//   BYTE_EN                 : byteenable driven on every transfer (full words only)
//   state_t                 : controller states
package sopc_2_mem_master_pkg;
    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 32;
    localparam int MEM_DEPTH = 12500;
    localparam logic [3:0] BYTE_EN = 4'hF;
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_DRAIN, S_FIN} state_t;
endpackage

// File: rtl/sopc_2_mem_master_fifo.sv
// sopc_2_mem_master_fifo: synchronous show-ahead FIFO with occupancy count
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write strobe and data (must not push when full)
//   pop        : read strobe (only while not empty)
//   dout       : head word, valid whenever empty is low
//   empty      : no words held
//   count      : words held, 0..DEPTH
module sopc_2_mem_master_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic full;
    assign dout = mem[rd_ptr];
    assign empty = count == '0;
    assign full = count == (PW+1)'(DEPTH);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
endmodule

// File: rtl/sopc_2_mem_master.sv
// sopc_2_mem_master: Avalon-MM master moving word blocks between memory and streams
//   Optional feature macro: SOPC_2_MEM_MASTER_BOUNDS_CHECK_EN (reject commands past MEM_DEPTH)
//   clk, reset_n                       : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready                : command handshake (ready only in IDLE)
//   cmd_write, cmd_addr, cmd_len       : direction (1 = stream->memory), base word address, word count
//   busy, done, error                  : transfer active, completion pulse, rejected-command pulse
//   avm_*                              : Avalon-MM master port (fixed-latency reads)
//   src_data/src_valid/src_ready       : read-mode output stream
//   snk_data/snk_valid/snk_ready       : write-mode input stream
module sopc_2_mem_master
    import sopc_2_mem_master_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    input  logic              src_ready,
    input  logic [DATA_W-1:0] snk_data,
    input  logic              snk_valid,
    output logic              snk_ready
);
    localparam int CW = $clog2(FIFO_DEPTH + READ_LATENCY) + 1;
    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    state_t state, state_n;
    logic [ADDR_W-1:0] addr, len, cnt;
    logic [READ_LATENCY-1:0] sr;
    logic [CW-1:0] inflight;
    logic [FW-1:0] fifo_count;
    logic fifo_empty, pop, rd_acc, wr_xfer, last, cmd_acc, oob;

    assign cmd_ready = state == S_IDLE;
`ifdef SOPC_2_MEM_MASTER_BOUNDS_CHECK_EN
    logic err_q;
    assign oob = ({1'b0, cmd_addr} + {1'b0, cmd_len}) > (ADDR_W+1)'(MEM_DEPTH);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_q <= 1'b0;
        else err_q <= cmd_ready & cmd_valid & oob;
    end
    assign error = err_q;
`else
    assign oob = 1'b0;
    assign error = 1'b0;
`endif
    assign cmd_acc = cmd_ready & cmd_valid & ~oob;
    assign busy = state inside {S_RD, S_WR, S_DRAIN};
    assign done = state == S_FIN;
    assign last = cnt + ADDR_W'(1) == len;
    // Credit rule: words in the FIFO plus reads still in the latency pipe never exceed
    // FIFO_DEPTH, so every return has a slot regardless of src_ready.
    assign avm_read = state == S_RD && (CW'(fifo_count) + inflight) < CW'(FIFO_DEPTH);
    assign avm_write = state == S_WR && snk_valid;
    assign snk_ready = state == S_WR && !avm_waitrequest;
    assign avm_writedata = snk_data;
    assign avm_byteenable = BYTE_EN;
    assign avm_address = addr;
    assign rd_acc = avm_read & ~avm_waitrequest;
    assign wr_xfer = snk_valid & snk_ready;
    assign src_valid = ~fifo_empty;
    assign pop = src_valid & src_ready;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(sr[i]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            addr <= '0;
            len <= '0;
            cnt <= '0;
            sr <= '0;
        end else begin
            state <= state_n;
            sr <= (sr << 1) | READ_LATENCY'(rd_acc);
            if (cmd_acc) begin
                addr <= cmd_addr;
                len <= cmd_len;
                cnt <= '0;
            end else if (rd_acc | wr_xfer) begin
                addr <= addr + ADDR_W'(1);
                cnt <= cnt + ADDR_W'(1);
            end
        end
    end

    // A zero-length command passes through DRAIN (which completes at once) so that
    // done lands two cycles after accept. DRAIN also exits on the cycle the final
    // word is popped, so done trails the last src handshake by exactly one cycle.
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (cmd_acc) state_n = cmd_len == '0 ? S_DRAIN : cmd_write ? S_WR : S_RD;
            S_RD:    if (rd_acc && last) state_n = S_DRAIN;
            S_WR:    if (wr_xfer && last) state_n = S_FIN;
            S_DRAIN: if (inflight == '0 && (fifo_count == '0 || (fifo_count == FW'(1) && pop))) state_n = S_FIN;
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    sopc_2_mem_master_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .push  (sr[READ_LATENCY-1]),
        .din   (avm_readdata),
        .pop   (pop),
        .dout  (src_data),
        .empty (fifo_empty),
        .count (fifo_count)
    );
endmodule

// File: tb/tb_sopc_2_mem_master.sv
// tb_sopc_2_mem_master: scoreboard bench for the Avalon-MM block mover
module tb_sopc_2_mem_master;
    localparam int AW = 14;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic cmd_valid, cmd_ready, cmd_write, busy, done, error;
    logic [AW-1:0] cmd_addr, cmd_len, avm_address;
    logic avm_read, avm_write, avm_waitrequest;
    logic [3:0] avm_byteenable;
    logic [DW-1:0] avm_writedata, avm_readdata, src_data, snk_data;
    logic src_valid, src_ready, snk_valid, snk_ready;

    always #5 clk = ~clk;

    sopc_2_mem_master dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_byteenable  (avm_byteenable),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .src_data        (src_data),
        .src_valid       (src_valid),
        .src_ready       (src_ready),
        .snk_data        (snk_data),
        .snk_valid       (snk_valid),
        .snk_ready       (snk_ready)
    );

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory slave: unwritten words read back as 0xA5000000 + address, one-cycle read latency
    logic [DW-1:0] mem [int];
    logic [DW-1:0] rdata = '0;
    assign avm_readdata = rdata;

    function automatic logic [DW-1:0] mem_word(input int a);
        return mem.exists(a) ? mem[a] : 32'hA500_0000 + 32'(a);
    endfunction

    always @(posedge clk) begin
        if (avm_write && !avm_waitrequest) mem[int'(avm_address)] = avm_writedata;
        if (avm_read && !avm_waitrequest) rdata <= mem_word(int'(avm_address));
    end

    // Scoreboard and bus monitor
    logic [DW-1:0] q [$];
    logic [DW-1:0] exp_w;
    int cyc = 0, hs_cnt = 0, rd_cnt = 0, bus_cnt = 0, done_cnt = 0, done_cyc = 0, last_hs = 0, out_cnt = 0;
    int t_acc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset_n) out_cnt = 0;
        else begin
            if (avm_read || avm_write) bus_cnt++;
            if (avm_read) chk("rd_wr_excl", avm_write, 0);
            if (avm_read && !avm_waitrequest) begin
                rd_cnt++;
                out_cnt++;
            end
            if (src_valid && src_ready) begin
                if (q.size() != 0) exp_w = q.pop_front();
                else exp_w = ~src_data;
                chk("src_data", src_data, exp_w);
                out_cnt--;
                hs_cnt++;
                last_hs = cyc;
            end
            if (avm_read) chk("credit_le_depth", out_cnt <= 4, 1);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic reset_chk(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_avm_read"}, avm_read, 0);
        chk({tag, "_avm_write"}, avm_write, 0);
        chk({tag, "_src_valid"}, src_valid, 0);
        chk({tag, "_snk_ready"}, snk_ready, 0);
        chk({tag, "_avm_address"}, 32'(avm_address), 0);
        chk({tag, "_byteenable"}, 32'(avm_byteenable), 32'hF);
    endtask

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [AW-1:0] l);
        @(negedge clk);
        chk("cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr = a;
        cmd_len = l;
        t_acc = cyc;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 300);
        chk(tag, done, 1);
        #1;
    endtask

    task automatic send_words(input int n, input logic [31:0] base);
        int k;
        for (int i = 0; i < n; i++) begin
            k = 0;
            snk_valid = 1'b1;
            snk_data = base + 32'(i);
            @(negedge clk);
            while (!snk_ready && k < 50) begin
                @(negedge clk);
                k++;
            end
            chk("snk_accept", snk_ready, 1);
            @(posedge clk);
            #1;
        end
        snk_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int t, h0, r0, b0, d0, k;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        avm_waitrequest = 0; src_ready = 0; snk_valid = 0; snk_data = '0;
        #1 reset_n = 1'b0;
        #2 reset_chk("rst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Read 4 words from 0x0010 with src_ready high
        src_ready = 1'b1;
        for (int i = 0; i < 4; i++) q.push_back(32'hA500_0010 + 32'(i));
        h0 = hs_cnt;
        issue(0, 14'h0010, 14'd4);
        t = t_acc;
        #1 chk("t1_busy", busy, 1);
        wait_done("t1_done");
        chk("t1_last_hs_cycle", 32'(last_hs), 32'(t + 6));
        chk("t1_done_cycle", 32'(done_cyc), 32'(t + 7));
        chk("t1_words", 32'(hs_cnt - h0), 4);
        chk("t1_q_empty", 32'(q.size()), 0);
        @(negedge clk);
        chk("t1_done_pulse", done, 0);

        // Read 10 words with backpressure: src_ready low 20 cycles, then toggling
        src_ready = 1'b0;
        for (int i = 0; i < 10; i++) q.push_back(32'hA500_0100 + 32'(i));
        h0 = hs_cnt;
        r0 = rd_cnt;
        issue(0, 14'h0100, 14'd10);
        repeat (20) @(negedge clk);
        #1;
        chk("t2_stalled_reads", 32'(rd_cnt - r0), 4);
        chk("t2_src_valid", src_valid, 1);
        chk("t2_avm_read_stall", avm_read, 0);
        k = 0;
        while (!done && k < 200) begin
            @(posedge clk);
            #1 src_ready = ~src_ready;
            k++;
        end
        chk("t2_done", done, 1);
        src_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("t2_words", 32'(hs_cnt - h0), 10);
        chk("t2_reads", 32'(rd_cnt - r0), 10);
        chk("t2_q_empty", 32'(q.size()), 0);

        // Write 3 words at 0x3000, waitrequest high for 2 cycles on the 2nd write
        issue(1, 14'h3000, 14'd3);
        snk_valid = 1'b1;
        snk_data = 32'h11;
        @(negedge clk);
        chk("t3_snk_ready0", snk_ready, 1);
        chk("t3_avm_write0", avm_write, 1);
        chk("t3_addr0", 32'(avm_address), 32'h3000);
        chk("t3_wdata0", avm_writedata, 32'h11);
        @(posedge clk);
        #1 snk_data = 32'h22;
        avm_waitrequest = 1'b1;
        @(negedge clk);
        chk("t3_snk_ready_wait1", snk_ready, 0);
        chk("t3_avm_write_held", avm_write, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t3_snk_ready_wait2", snk_ready, 0);
        @(posedge clk);
        #1 avm_waitrequest = 1'b0;
        @(negedge clk);
        chk("t3_snk_ready1", snk_ready, 1);
        chk("t3_addr1", 32'(avm_address), 32'h3001);
        @(posedge clk);
        #1 snk_data = 32'h33;
        @(posedge clk);
        #1 snk_valid = 1'b0;
        @(negedge clk);
        chk("t3_done", done, 1);
        chk("t3_mem0", mem_word(32'h3000), 32'h11);
        chk("t3_mem1", mem_word(32'h3001), 32'h22);
        chk("t3_mem2", mem_word(32'h3002), 32'h33);
        q.push_back(32'h11);
        q.push_back(32'h22);
        q.push_back(32'h33);
        issue(0, 14'h3000, 14'd3);
        wait_done("t3_readback_done");
        chk("t3_readback_q_empty", 32'(q.size()), 0);

        // Zero-length command
        b0 = bus_cnt;
        issue(0, 14'h0050, 14'd0);
        @(negedge clk);
        chk("t4_busy_t1", busy, 1);
        chk("t4_done_t1", done, 0);
        @(negedge clk);
        chk("t4_done_t2", done, 1);
        @(negedge clk);
        chk("t4_done_t3", done, 0);
        #1 chk("t4_no_bus", 32'(bus_cnt - b0), 0);

        // Command reaching past MEM_DEPTH
`ifdef SOPC_2_MEM_MASTER_BOUNDS_CHECK_EN
        b0 = bus_cnt;
        d0 = done_cnt;
        snk_valid = 1'b1;
        issue(1, 14'd12498, 14'd4);
        @(negedge clk);
        chk("t5_error", error, 1);
        chk("t5_busy", busy, 0);
        chk("t5_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        chk("t5_error_pulse", error, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("t5_no_bus", 32'(bus_cnt - b0), 0);
        chk("t5_no_done", 32'(done_cnt - d0), 0);
        snk_valid = 1'b0;
`else
        issue(1, 14'd12498, 14'd4);
        send_words(4, 32'hB0);
        wait_done("t5_done");
        for (int i = 0; i < 4; i++) chk("t5_mem", mem_word(12498 + i), 32'hB0 + 32'(i));
        chk("t5_error", error, 0);
`endif

        // Reset during a len-8 read after 3 words
        src_ready = 1'b1;
        for (int i = 0; i < 8; i++) q.push_back(32'hA500_0200 + 32'(i));
        h0 = hs_cnt;
        issue(0, 14'h0200, 14'd8);
        k = 0;
        while (hs_cnt - h0 < 3 && k < 100) begin
            @(posedge clk);
            k++;
        end
        chk("t6_three_words", 32'(hs_cnt - h0), 3);
        #2 reset_n = 1'b0;
        #1 reset_chk("t6_rst");
        q.delete();
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        #1 chk("t6_no_done", 32'(done_cnt - d0), 0);
        q.push_back(32'hA500_0020);
        q.push_back(32'hA500_0021);
        issue(0, 14'h0020, 14'd2);
        wait_done("t6_after_reset_done");
        chk("t6_q_empty", 32'(q.size()), 0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
